// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg: opcode, flag and arbiter-state types shared by the ALU arbiter slice
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NEG  = 3'd5,
    ALU_PASS = 3'd6,
    ALU_NOP  = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam alu_op_t OP_NOP = ALU_NOP;

  function automatic logic is_reserved(input logic [2:0] op);
    return op == OP_NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if: request/response handshakes between requesters and the arbiter
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
);
  import alu_pkg::*;

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0][2:0]       req_op;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready;
  logic [WIDTH-1:0]           rsp_result;
  alu_flags_t                 rsp_flags;
  logic                       rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, searching from last_grant + 1
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NREQ);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter: shares one combinational ALU among NREQ requesters round-robin
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags
);

  localparam int IW = $clog2(NREQ);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    grant_q;
  logic [IW-1:0]    win_idx;
  logic [NREQ-1:0]  win_onehot;
  logic             arb_en;
  logic             accept;
  logic             legal;
  logic             rsp_fire;
  logic [2:0]       win_op;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic             err_q;

  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign arb_en = rst_n && (state == ST_IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .en         (arb_en),
    .grant      (win_onehot),
    .grant_idx  (win_idx)
  );

  assign accept   = |win_onehot;
  assign win_op   = bus.req_op[win_idx];
  assign legal    = !is_reserved(win_op);
  assign rsp_fire = (state == ST_RESP) && bus.rsp_ready[grant_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = win_onehot;
        if (accept) begin
          state_nxt = legal ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ALU operand registers are loaded only on a legal accept, so they carry
  // the operation for exactly the EXEC cycle and sit at NOP/0 otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_NOP;
      grant_q    <= '0;
      last_grant <= IW'(NREQ - 1);
      result_q   <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= OP_NOP;
      if (accept) begin
        grant_q <= win_idx;
        if (legal) begin
          alu_a  <= bus.req_a[win_idx];
          alu_b  <= bus.req_b[win_idx];
          alu_op <= win_op;
        end else begin
          result_q <= '0;
          flags_q  <= '0;
          err_q    <= 1'b1;
        end
      end
      if (state == ST_EXEC) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
        err_q    <= 1'b0;
      end
      if (rsp_fire) begin
        last_grant <= grant_q;
      end
    end
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_err    = err_q;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU (adder/two's-complement/logic unit) between `NREQ` requesters, e.g. the SHA round engine and the message-schedule unit. It accepts one operation at a time over a valid/ready handshake, picks between requesters round-robin, and drives registered operands to the ALU. It captures the result and flags and returns them to the winning requester over a second valid/ready handshake.

## Interface
- `WIDTH`, 32: operand/result width.
- `NREQ`, 2: number of requesters (2..4).
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NREQ  request pending, per requester.
- `req_ready`  out  NREQ  request accepted this cycle, one-hot or zero.
- `req_a`, `req_b`  in  NREQ×WIDTH  operands, per requester.
- `req_op`  in  NREQ×3  operation code, per requester.
- `rsp_valid`  out  NREQ  response available, one-hot or zero.
- `rsp_ready`  in  NREQ  requester takes response.
- `rsp_result`  out  WIDTH  shared response data.
- `rsp_flags`  out  4  {N,Z,C,V} from ALU.
- `rsp_err`  out  1  reserved opcode rejected.
- `alu_a`, `alu_b`  out  WIDTH  registered ALU operands.
- `alu_op`  out  3  registered ALU opcode.
- `alu_result`  in  WIDTH  combinational ALU result.
- `alu_flags`  in  4  combinational ALU flags.

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NEG=5 (two's complement of a), PASS=6, NOP=7 (reserved, never issued).
- FSM IDLE → EXEC → RESP → IDLE.
- IDLE:
  - Arbitrate among `req_valid`. Round-robin starts from the requester after `last_grant`.
  - Assert `req_ready[g]` combinationally for winner g only.
  - On accept: latch a, b, op, and g.
  - Legal op: go to EXEC.
  - NOP (7): go straight to RESP with `rsp_err`=1, result 0, flags 0. The ALU is not issued.
- EXEC:
  - `alu_a/b/op` hold the latched values for exactly one cycle.
  - Capture `alu_result`/`alu_flags` at the end of the cycle, then go to RESP.
- RESP:
  - `rsp_valid[g]`=1 with stable result/flags/err until `rsp_ready[g]`.
  - On `rsp_valid & rsp_ready`: go to IDLE and set `last_grant`=g.
  - `rsp_ready` of non-granted requesters is ignored.
- Outside EXEC, `alu_op`=NOP and `alu_a/b`=0.
- Requesters must hold `req_valid` and payload stable until `req_ready`. The block only samples them on the accept cycle.
- Requests arriving during EXEC/RESP wait. No request is ever dropped.

## Timing
- Reset values:
  - state IDLE, `last_grant`=NREQ-1, so requester 0 wins the first tie.
  - `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_err`=0.
  - `alu_a`=`alu_b`=0, `alu_op`=NOP.
- `req_ready` is 0 while `rst_n`=0.
- Legal op latency: accept at edge T, ALU driven T..T+1, `rsp_valid` high from T+2.
- Reserved op latency: `rsp_valid` from T+1.
- Throughput: minimum 3 cycles per legal op with `rsp_ready` held high, 2 per reserved op. There is no IDLE bypass.
- Simultaneous requests: exactly one is granted per IDLE cycle. A continuously requesting peer is served within NREQ grants.
- A requester may deassert `req_valid` before grant. A request withdrawn this way is not a transaction.
- Reset mid-operation (EXEC or RESP): abort on the next edge. No response is produced, and the ALU outputs return to reset values.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum with the opcodes above.
  - `alu_flags_t` packed struct {n,z,c,v}.
  - `arb_state_t` enum.
  - `OP_NOP` constant.
- Sub-module `rr_arbiter` (parameter NREQ):
  - inputs: request vector, `last_grant`, enable.
  - outputs: one-hot grant and index.
  - purely combinational.
- The top holds the FSM, payload/result registers and `last_grant`.

## Test plan
- Single request, requester 0: ADD a=32'h0000_0005, b=32'h0000_0003. Expect `alu_op`=0 for one cycle, `rsp_valid[0]` at T+2, `rsp_result`=8, flags 4'b0000.
- Requester 1 NEG a=32'h0000_0005. Expect `rsp_result`=32'hFFFF_FFFB, N=1. Then SUB 5−5, expect result 0, Z=1, C=1.
- Both requesters hold valid for 4 transactions:
  - grant order 0,1,0,1;
  - each response routed to the matching `rsp_valid` bit;
  - `rsp_result` matches each requester's own operands.
- Reserved op 7 from requester 0:
  - `rsp_valid[0]` at T+1 with `rsp_err`=1, result 0;
  - `alu_op` stays NOP throughout.
- Backpressure:
  - hold `rsp_ready[0]`=0 for 5 cycles; result/flags stay stable;
  - a pending requester 1 request is not accepted until the response completes.
- Reset mid-op:
  - drive `rst_n`=0 during EXEC;
  - next cycle all outputs are at reset values, no `rsp_valid` appears;
  - a post-reset tie grants requester 0.
